// File: rtl/dmips_mem_pkg.sv
// Shared types and defaults for the dataram load/store path.
// Size encodings, FSM states and the misalignment rule live here.
package dmips_mem_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int BUS_WIDTH_DEF  = 17;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_e;

    // Reserved size is folded into the misaligned case.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            size == SIZE_HALF: bad = off[0];
            size == SIZE_WORD: bad = |off;
            size == SIZE_RSVD: bad = 1'b1;
            default:           bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for stores.
// Purely combinational; the word input is the raw dataram word.
module lsu_lane_align
    import dmips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [1:0]            size,
    input  logic                  sign,
    input  logic [1:0]            off,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b    = word[{off, 3'b000} +: 8];
        lane_h    = word[{off[1], 4'b0000} +: 16];
        load_data = word;
        merged    = wdata;
        unique case (1'b1)
            size == SIZE_BYTE: begin
                load_data = {{(DATA_WIDTH-8){sign & lane_b[7]}}, lane_b};
                merged    = word;
                merged[{off, 3'b000} +: 8] = wdata[7:0];
            end
            size == SIZE_HALF: begin
                load_data = {{(DATA_WIDTH-16){sign & lane_h[15]}}, lane_h};
                merged    = word;
                merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a combinational dataram.
// Sub-word stores do a read-modify-write through READ then WRITE.
module load_store_unit
    import dmips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [BUS_WIDTH+1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  memwrite,
    output logic [BUS_WIDTH-1:0]  adr,
    output logic [DATA_WIDTH-1:0] writedata,
    input  logic [DATA_WIDTH-1:0] readdata
);

    state_e                state;
    logic                  lat_write;
    logic [1:0]            lat_size;
    logic                  lat_signed;
    logic [1:0]            lat_off;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged;

    assign req_ready = (state == IDLE);

    lsu_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .size      (lat_size),
        .sign      (lat_signed),
        .off       (lat_off),
        .word      (readdata),
        .wdata     (lat_wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lat_write  <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_off    <= 2'b00;
            lat_wdata  <= '0;
            memwrite   <= 1'b0;
            adr        <= '0;
            writedata  <= '0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_off    <= req_addr[1:0];
                        lat_wdata  <= req_wdata;
                        adr        <= req_addr[BUS_WIDTH+1:2];
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else if (req_write && req_size == SIZE_WORD) begin
                            state     <= WRITE;
                            memwrite  <= 1'b1;
                            writedata <= req_wdata;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (lat_write) begin
                        state     <= WRITE;
                        memwrite  <= 1'b1;
                        writedata <= merged;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    memwrite   <= 1'b0;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

endmodule
